// File: rtl/tm_pkg.sv
// tm_pkg: move encodings, transition-entry struct and width helper shared by the TM control unit.
package tm_pkg;
    localparam int TM_ST_W_MAX  = 8;
    localparam int TM_SYM_W_MAX = 8;
    typedef enum logic [1:0] {
        MOVE_STAY  = 2'b00,
        MOVE_RIGHT = 2'b01,
        MOVE_LEFT  = 2'b10,
        MOVE_RSVD  = 2'b11
    } tm_move_t;
    // Fields sized for the widest supported machine; narrower instances zero-extend.
    typedef struct packed {
        logic                    valid;
        logic [TM_ST_W_MAX-1:0]  next;
        logic [TM_SYM_W_MAX-1:0] wsym;
        tm_move_t                move;
    } tm_entry_t;
    function automatic int clog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/tm_control_unit_if.sv
// tm_control_unit_if: program-load port, step handshake and status outputs of the TM control unit.
interface tm_control_unit_if import tm_pkg::*; #(
    parameter int NUM_STATES = 8,
    parameter int SYM_W      = 3,
    parameter int CNT_W      = 16
);
    localparam int ST_W = clog2(NUM_STATES);
    logic                  prog_we;
    logic [ST_W-1:0]       prog_state;
    logic [SYM_W-1:0]      prog_sym;
    logic [ST_W-1:0]       prog_next;
    logic [SYM_W-1:0]      prog_wsym;
    logic [1:0]            prog_move;
    logic                  restart;
    logic                  step_valid;
    logic                  step_ready;
    logic [SYM_W-1:0]      sym_in;
    logic                  resp_valid;
    logic [SYM_W-1:0]      wsym_out;
    logic [1:0]            move_out;
    logic [NUM_STATES-1:0] state_onehot;
    logic                  halted;
    logic                  fault;
    logic [CNT_W-1:0]      step_count;
    modport master (
        output prog_we, prog_state, prog_sym, prog_next, prog_wsym, prog_move, restart, step_valid, sym_in,
        input  step_ready, resp_valid, wsym_out, move_out, state_onehot, halted, fault, step_count
    );
    modport slave (
        input  prog_we, prog_state, prog_sym, prog_next, prog_wsym, prog_move, restart, step_valid, sym_in,
        output step_ready, resp_valid, wsym_out, move_out, state_onehot, halted, fault, step_count
    );
endinterface

// File: rtl/tm_trans_table.sv
// tm_trans_table: transition table with synchronous write, asynchronous read and async-cleared valid bits.
module tm_trans_table import tm_pkg::*; #(
    parameter int IDX_W = 6,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  tm_entry_t        i_wr_ent,
    input  logic [IDX_W-1:0] i_rd_idx,
    output tm_entry_t        o_rd_ent
);
    tm_entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    tm_entry_t        w_rd;
    logic             w_unused;
    // Only the valid bits need reset; entry payload is don't-care until written.
    always_ff @(posedge clk or posedge reset)
        if (reset) r_valid <= '0;
        else if (i_we) r_valid[i_wr_idx] <= i_wr_ent.valid;
    always_ff @(posedge clk)
        if (i_we) r_mem[i_wr_idx] <= i_wr_ent;
    assign w_rd     = r_mem[i_rd_idx];
    assign o_rd_ent = {r_valid[i_rd_idx], w_rd.next, w_rd.wsym, w_rd.move};
    assign w_unused = w_rd.valid;
endmodule

// File: rtl/tm_control_unit.sv
// tm_control_unit: registered Turing-machine control with loadable transition table and step handshake.
// Define TM_STEP_COUNT_EN to enable the saturating accepted-step counter.
module tm_control_unit import tm_pkg::*; #(
    parameter int NUM_STATES  = 8,
    parameter int SYM_W       = 3,
    parameter int START_STATE = 0,
    parameter int HALT_STATE  = NUM_STATES - 1,
    parameter int CNT_W       = 16
) (
    input logic              clk,
    input logic              reset,
    tm_control_unit_if.slave bus
);
    localparam int ST_W  = clog2(NUM_STATES);
    localparam int IDX_W = ST_W + SYM_W;
    logic [ST_W-1:0]  r_state;
    logic [SYM_W-1:0] r_wsym;
    tm_move_t         r_move;
    logic             r_fault;
    logic             r_resp_valid;
    logic             w_halted;
    logic             w_ready;
    logic             w_accept;
    tm_entry_t        w_wr_ent;
    tm_entry_t        w_rd_ent;
    logic             w_unused;
    // The reserved move code is folded to stay at load time so lookups never see it.
    assign w_wr_ent = {1'b1, TM_ST_W_MAX'(bus.prog_next), TM_SYM_W_MAX'(bus.prog_wsym),
                       tm_move_t'(bus.prog_move == MOVE_RSVD ? MOVE_STAY : bus.prog_move)};
    tm_trans_table #(.IDX_W(IDX_W), .DEPTH(NUM_STATES << SYM_W)) u_table (
        .clk      (clk),
        .reset    (reset),
        .i_we     (bus.prog_we),
        .i_wr_idx ({bus.prog_state, bus.prog_sym}),
        .i_wr_ent (w_wr_ent),
        .i_rd_idx ({r_state, bus.sym_in}),
        .o_rd_ent (w_rd_ent)
    );
    assign w_unused = ^{w_rd_ent.next, w_rd_ent.wsym};
    assign w_halted = r_state == ST_W'(HALT_STATE);
    assign w_ready  = !bus.prog_we && !bus.restart && !w_halted && !r_fault;
    assign w_accept = bus.step_valid && w_ready;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state      <= ST_W'(START_STATE);
            r_wsym       <= '0;
            r_move       <= MOVE_STAY;
            r_fault      <= 1'b0;
            r_resp_valid <= 1'b0;
        end else if (bus.restart) begin
            r_state      <= ST_W'(START_STATE);
            r_fault      <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_resp_valid <= w_accept;
            if (w_accept && w_rd_ent.valid) begin
                r_state <= w_rd_ent.next[ST_W-1:0];
                r_wsym  <= w_rd_ent.wsym[SYM_W-1:0];
                r_move  <= w_rd_ent.move;
            end else if (w_accept) begin
                r_fault <= 1'b1;
                r_wsym  <= bus.sym_in;
                r_move  <= MOVE_STAY;
            end
        end
`ifdef TM_STEP_COUNT_EN
    logic [CNT_W-1:0] r_count;
    always_ff @(posedge clk or posedge reset)
        if (reset) r_count <= '0;
        else if (bus.restart) r_count <= '0;
        else if (w_accept && r_count != '1) r_count <= r_count + CNT_W'(1);
    assign bus.step_count = r_count;
`else
    assign bus.step_count = '0;
`endif
    assign bus.step_ready   = w_ready;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.wsym_out     = r_wsym;
    assign bus.move_out     = r_move;
    assign bus.state_onehot = NUM_STATES'(1) << r_state;
    assign bus.halted       = w_halted;
    assign bus.fault        = r_fault;
endmodule

// File: tb/tb_tm_control_unit.sv
// tb_tm_control_unit: scoreboard bench driving directed program/step vectors into tm_control_unit.
module tb_tm_control_unit;
    typedef struct {
        logic [2:0] wsym;
        logic [1:0] move;
        logic [7:0] oh;
        logic       fault;
    } exp_t;
`ifdef TM_STEP_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t q[$];
    tm_control_unit_if #(.NUM_STATES(8), .SYM_W(3), .CNT_W(4)) bus();
    tm_control_unit #(.NUM_STATES(8), .SYM_W(3), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [31:0] exp_cnt(input int n);
        return CNT_ON ? ((n > 15) ? 15 : n) : 0;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic prog(input logic [2:0] st, input logic [2:0] sym, input logic [2:0] nx,
                        input logic [2:0] ws, input logic [1:0] mv);
        bus.prog_we = 1'b1;
        bus.prog_state = st;
        bus.prog_sym = sym;
        bus.prog_next = nx;
        bus.prog_wsym = ws;
        bus.prog_move = mv;
        tick();
        bus.prog_we = 1'b0;
    endtask
    task automatic expect_resp(input logic [2:0] ws, input logic [1:0] mv, input logic [7:0] oh, input logic f);
        q.push_back('{ws, mv, oh, f});
    endtask
    task automatic step(input logic [2:0] sym);
        bus.step_valid = 1'b1;
        bus.sym_in = sym;
        tick();
        bus.step_valid = 1'b0;
    endtask
    task automatic do_restart();
        bus.restart = 1'b1;
        tick();
        bus.restart = 1'b0;
    endtask
    // Monitor: every response pulse must match the oldest outstanding expectation.
    initial forever begin
        @(negedge clk);
        if (bus.resp_valid) begin
            if (q.size() == 0) chk("resp_unexpected", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_wsym", bus.wsym_out, e.wsym);
                chk("resp_move", bus.move_out, e.move);
                chk("resp_state", bus.state_onehot, e.oh);
                chk("resp_fault", bus.fault, e.fault);
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.prog_we = 0; bus.prog_state = 0; bus.prog_sym = 0; bus.prog_next = 0;
        bus.prog_wsym = 0; bus.prog_move = 0; bus.restart = 0; bus.step_valid = 0; bus.sym_in = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", bus.state_onehot, 8'h01);
        chk("rst_halted", bus.halted, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_resp", bus.resp_valid, 0);
        chk("rst_ready", bus.step_ready, 1);
        chk("rst_wsym", bus.wsym_out, 0);
        chk("rst_move", bus.move_out, 0);
        chk("rst_count", bus.step_count, 0);
        reset = 1'b0;
        tick();
        prog(0, 0, 1, 3'b101, 2'b01);
        expect_resp(3'b101, 2'b01, 8'h02, 0);
        step(0);
        @(negedge clk);
        chk("basic_count", bus.step_count, exp_cnt(1));
        expect_resp(3'b011, 2'b00, 8'h02, 1);
        step(3'b011);
        @(negedge clk);
        chk("fault_flag", bus.fault, 1);
        chk("fault_ready", bus.step_ready, 0);
        chk("fault_state", bus.state_onehot, 8'h02);
        chk("fault_count", bus.step_count, exp_cnt(2));
        bus.step_valid = 1'b1;
        bus.sym_in = 0;
        repeat (2) tick();
        bus.step_valid = 1'b0;
        do_restart();
        @(negedge clk);
        chk("restart_fault", bus.fault, 0);
        chk("restart_state", bus.state_onehot, 8'h01);
        chk("restart_ready", bus.step_ready, 1);
        chk("restart_count", bus.step_count, 0);
        prog(0, 1, 2, 1, 2'b01);
        prog(2, 1, 5, 2, 2'b10);
        prog(5, 1, 7, 3, 2'b11);
        expect_resp(1, 2'b01, 8'h04, 0);
        expect_resp(2, 2'b10, 8'h20, 0);
        expect_resp(3, 2'b00, 8'h80, 0);
        bus.step_valid = 1'b1;
        bus.sym_in = 1;
        repeat (5) tick();
        bus.step_valid = 1'b0;
        @(negedge clk);
        chk("halt_halted", bus.halted, 1);
        chk("halt_ready", bus.step_ready, 0);
        chk("halt_state", bus.state_onehot, 8'h80);
        chk("halt_count", bus.step_count, exp_cnt(3));
        do_restart();
        bus.prog_we = 1'b1;
        bus.prog_state = 0; bus.prog_sym = 2; bus.prog_next = 3; bus.prog_wsym = 6; bus.prog_move = 2'b10;
        bus.step_valid = 1'b1;
        bus.sym_in = 2;
        @(negedge clk);
        chk("collide_ready", bus.step_ready, 0);
        @(posedge clk);
        #1;
        bus.prog_we = 1'b0;
        expect_resp(6, 2'b10, 8'h08, 0);
        @(negedge clk);
        chk("collide_resp", bus.resp_valid, 0);
        chk("collide_ready_after", bus.step_ready, 1);
        tick();
        bus.step_valid = 1'b0;
        @(negedge clk);
        chk("collide_state", bus.state_onehot, 8'h08);
        do_restart();
        prog(0, 4, 0, 4, 2'b01);
        repeat (20) expect_resp(4, 2'b01, 8'h01, 0);
        bus.step_valid = 1'b1;
        bus.sym_in = 4;
        repeat (20) tick();
        bus.step_valid = 1'b0;
        @(negedge clk);
        chk("sat_count", bus.step_count, exp_cnt(20));
        prog(0, 5, 6, 7, 2'b10);
        expect_resp(7, 2'b10, 8'h40, 0);
        step(5);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_state", bus.state_onehot, 8'h01);
        chk("arst_wsym", bus.wsym_out, 0);
        chk("arst_move", bus.move_out, 0);
        chk("arst_fault", bus.fault, 0);
        chk("arst_resp", bus.resp_valid, 0);
        chk("arst_count", bus.step_count, 0);
        chk("arst_halted", bus.halted, 0);
        tick();
        reset = 1'b0;
        expect_resp(4, 2'b00, 8'h01, 1);
        step(4);
        @(negedge clk);
        chk("arst_table_cleared", bus.fault, 1);
        repeat (3) tick();
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
